// File: rtl/sensor_condition_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sensor_condition_unit: debounced tank switches plus moisture hysteresis   |
// | drive registered watering / filling requests.   Revision 1.0             |
// +--------------------------------------------------------------------------+
module sensor_condition_unit #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [7:0] DRY_THRESHOLD   = 8'd80,
  parameter logic [7:0] WET_THRESHOLD   = 8'd120,
  parameter int         STALE_CYCLES    = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tank_low,
  input  logic       tank_high,
  input  logic [7:0] moisture,
  input  logic       moisture_valid,
  output logic       watering_condition,
  output logic       filling_condition,
  output logic       sensor_fault,
  output logic       moisture_stale
);

  localparam int                 STALE_W    = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);
  localparam logic [7:0]         DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = tank_low, bit 1 = tank_high.
  logic [1:0] sw_raw;
  logic [1:0] deb_d;
  logic [1:0] deb_q;

  assign sw_raw = {tank_high, tank_low};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_switch
      logic [1:0] sync_d, sync_q;
      logic [7:0] cnt_d, cnt_q;
      logic       sw_deb_d, sw_deb_q;

      always_comb begin
        sync_d   = {sync_q[0], sw_raw[i]};
        sw_deb_d = sw_deb_q;
        cnt_d    = '0;
        // The flip edge also leaves the counter at zero.
        if (sync_q[1] != sw_deb_q) begin
          if (cnt_q == DB_LAST) begin
            sw_deb_d = ~sw_deb_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          sync_q   <= '0;
          cnt_q    <= '0;
          sw_deb_q <= 1'b0;
        end else begin
          sync_q   <= sync_d;
          cnt_q    <= cnt_d;
          sw_deb_q <= sw_deb_d;
        end
      end

      assign deb_d[i] = sw_deb_d;
      assign deb_q[i] = sw_deb_q;
    end
  endgenerate

  logic               need_fill_d, need_fill_q;
  logic               soil_dry_d, soil_dry_q;
  logic [STALE_W-1:0] stale_cnt_d, stale_cnt_q;
  logic               stale_d, stale_q;
  logic               watering_d, watering_q;
  logic               filling_d, filling_q;
  logic               fault_d, fault_q;
  logic               mstale_d, mstale_q;
  logic               fault;

  always_comb begin
    // need_fill tracks the debounced values of this edge so the request
    // lands one edge after the debounced flip.
    need_fill_d = need_fill_q;
    if (deb_d[0] && !deb_d[1]) begin
      need_fill_d = 1'b1;
    end else if (!deb_d[0] && deb_d[1]) begin
      need_fill_d = 1'b0;
    end

    soil_dry_d  = soil_dry_q;
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (moisture_valid) begin
      stale_cnt_d = '0;
      stale_d     = 1'b0;
      if (moisture < DRY_THRESHOLD) begin
        soil_dry_d = 1'b1;
      end else if (moisture > WET_THRESHOLD) begin
        soil_dry_d = 1'b0;
      end
    end else if (stale_cnt_q != STALE_MAX) begin
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
      if (stale_cnt_q == STALE_LAST) begin
        stale_d    = 1'b1;
        soil_dry_d = 1'b0;
      end
    end

    fault      = deb_q[0] & deb_q[1];
    fault_d    = fault;
    mstale_d   = stale_q;
    filling_d  = need_fill_q & ~fault;
    watering_d = soil_dry_q & ~stale_q & ~deb_q[0] & ~need_fill_q & ~fault;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      need_fill_q <= 1'b0;
      soil_dry_q  <= 1'b0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
      watering_q  <= 1'b0;
      filling_q   <= 1'b0;
      fault_q     <= 1'b0;
      mstale_q    <= 1'b0;
    end else begin
      need_fill_q <= need_fill_d;
      soil_dry_q  <= soil_dry_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
      watering_q  <= watering_d;
      filling_q   <= filling_d;
      fault_q     <= fault_d;
      mstale_q    <= mstale_d;
    end
  end

  assign watering_condition = watering_q;
  assign filling_condition  = filling_q;
  assign sensor_fault       = fault_q;
  assign moisture_stale     = mstale_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_condition_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sensor_condition_unit: scoreboard bench for sensor_condition_unit.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sensor_condition_unit;

  localparam logic [3:0] M_W = 4'b1000;
  localparam logic [3:0] M_F = 4'b0100;
  localparam logic [3:0] M_S = 4'b0010;
  localparam logic [3:0] M_T = 4'b0001;
  localparam logic [3:0] M_ALL = 4'b1111;

  logic       clk = 1'b0;
  logic       reset;
  logic       tank_low;
  logic       tank_high;
  logic [7:0] moisture;
  logic       moisture_valid;
  logic       watering_condition;
  logic       filling_condition;
  logic       sensor_fault;
  logic       moisture_stale;

  sensor_condition_unit dut (
    .clock              (clk),
    .reset              (reset),
    .tank_low           (tank_low),
    .tank_high          (tank_high),
    .moisture           (moisture),
    .moisture_valid     (moisture_valid),
    .watering_condition (watering_condition),
    .filling_condition  (filling_condition),
    .sensor_fault       (sensor_fault),
    .moisture_stale     (moisture_stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] mask;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_result(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %b expected %b (W F S T)", tag, cyc, obs, exp);
    end
  endtask

  // Expectation for the outputs visible after edge (cyc + dcyc).
  task automatic expect_at(input int dcyc, input string tag, input logic [3:0] mask,
                           input logic [3:0] exp);
    exp_t e;
    e.cyc  = cyc + dcyc;
    e.tag  = tag;
    e.mask = mask;
    e.exp  = exp & mask;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [3:0] o;
    o = {watering_condition, filling_condition, sensor_fault, moisture_stale};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_result(sb[i].tag, o & sb[i].mask, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    moisture       = v;
    moisture_valid = 1'b1;
    step(1);
    moisture_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tank_low = 1'b0; tank_high = 1'b0;
    moisture = 8'd0; moisture_valid = 1'b0;
    expect_at(1, "reset_state", M_ALL, 4'b0000);
    step(2);
    reset = 1'b0;
    step(3);

    // Short tank_low pulse is filtered.
    tank_low = 1'b1;
    expect_at(7,  "pulse_f7",  M_F | M_S, 4'b0000);
    expect_at(8,  "pulse_f8",  M_F | M_S, 4'b0000);
    expect_at(10, "pulse_f10", M_F | M_S, 4'b0000);
    step(3);
    tank_low = 1'b0;
    step(12);

    // Held tank_low: filling rises exactly 7 edges later.
    tank_low = 1'b1;
    expect_at(6, "fill_rise_pre", M_F, 4'b0000);
    expect_at(7, "fill_rise",     M_ALL, M_F);
    step(12);

    // tank_high debounced with tank_low released: filling falls.
    tank_low = 1'b0; tank_high = 1'b1;
    expect_at(6, "fill_fall_pre", M_F, M_F);
    expect_at(7, "fill_fall",     M_F | M_S, 4'b0000);
    step(10);

    // Dry sample: watering two edges after the valid cycle.
    expect_at(1, "water_pre", M_W, 4'b0000);
    expect_at(2, "water_on",  M_W | M_F, M_W);
    sample(8'd60);
    step(3);

    // Hysteresis band and the wet threshold boundary.
    expect_at(2, "hold_100", M_W, M_W);
    sample(8'd100);
    expect_at(2, "hold_120", M_W, M_W);
    sample(8'd120);
    step(3);
    expect_at(1, "wet121_pre", M_W, M_W);
    expect_at(2, "wet121",     M_W, 4'b0000);
    sample(8'd121);
    step(3);
    expect_at(2, "dry_79", M_W, M_W);
    sample(8'd79);
    step(3);

    // Stale after STALE_CYCLES without a sample.
    expect_at(2, "dry_60", M_W, M_W);
    sample(8'd60);
    expect_at(1024, "stale_pre", M_W | M_T, M_W);
    expect_at(1025, "stale_on",  M_W | M_T, M_T);
    step(1030);

    // Sample on the expiry cycle keeps stale clear.
    expect_at(2, "unstale", M_T, 4'b0000);
    sample(8'd50);
    step(1023);
    expect_at(2, "expiry_valid", M_W | M_T, M_W);
    expect_at(3, "expiry_hold",  M_T, 4'b0000);
    sample(8'd50);
    step(5);

    // Fault: need_fill set, then both switches, then both released together.
    tank_low = 1'b1; tank_high = 1'b0;
    expect_at(7, "fault_setup", M_W | M_F | M_S, M_F);
    step(10);
    tank_high = 1'b1;
    expect_at(6, "fault_pre", M_F | M_S, M_F);
    expect_at(7, "fault_on",  M_W | M_F | M_S, M_S);
    step(10);
    tank_low = 1'b0; tank_high = 1'b0;
    expect_at(6, "fault_hold", M_F | M_S, M_S);
    expect_at(7, "fault_off",  M_W | M_F | M_S, M_F);
    step(10);

    // Back to watering, then reset during a debounce.
    tank_high = 1'b1;
    expect_at(7, "rewater", M_W | M_F, M_W);
    step(10);
    tank_high = 1'b0;
    step(10);
    tank_low = 1'b1;
    step(4);
    expect_at(0, "pre_reset_w", M_W, M_W);
    reset = 1'b1; moisture = 8'd60; moisture_valid = 1'b1;
    expect_at(1, "mid_reset", M_ALL, 4'b0000);
    step(1);
    reset = 1'b0; moisture_valid = 1'b0;
    expect_at(1, "post_rst_w1", M_W, 4'b0000);
    expect_at(2, "post_rst_w2", M_W, 4'b0000);
    expect_at(6, "restart_pre", M_F, 4'b0000);
    expect_at(7, "restart",     M_W | M_F | M_S, M_F);
    step(10);

    while (sb.size() > 0) begin
      check_result({sb[0].tag, "_unchecked"}, 4'bxxxx, sb[0].exp);
      sb.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sensor_condition_unit.md
SENSOR_CONDITION_UNIT -- requirements
Module: sensor_condition_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles (1..255) a level switch must differ before its debounced value flips.
REQ-002 SHALL have parameter DRY_THRESHOLD, default 8'd80, moisture below which soil is dry.
REQ-003 SHALL have parameter WET_THRESHOLD, default 8'd120, moisture above which soil is no longer dry; WET_THRESHOLD > DRY_THRESHOLD.
REQ-004 SHALL have parameter STALE_CYCLES, default 1024, cycles without a moisture sample before the data is stale.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tank_low  input  1  asynchronous level switch, 1 = water below low mark.
REQ-008 SHALL have port tank_high  input  1  asynchronous level switch, 1 = water at/above high mark.
REQ-009 SHALL have port moisture  input  8  unsigned soil-moisture sample, clock-domain synchronous.
REQ-010 SHALL have port moisture_valid  input  1  one-cycle strobe qualifying moisture.
REQ-011 SHALL have port watering_condition  output  1  registered request to water.
REQ-012 SHALL have port filling_condition  output  1  registered request to fill the tank.
REQ-013 SHALL have port sensor_fault  output  1  registered; both debounced switches asserted.
REQ-014 SHALL have port moisture_stale  output  1  registered; no sample within STALE_CYCLES.

Function
REQ-015 SHALL pass tank_low and tank_high each through a 2-flop synchronizer.
REQ-016 SHALL keep per switch a debounced value and a counter: counter increments while synced != debounced, clears to 0 while equal; on reaching DEBOUNCE_CYCLES debounced flips and counter clears in the same edge.
REQ-017 SHALL ignore any synced pulse shorter than DEBOUNCE_CYCLES cycles (no debounced change).
REQ-018 SHALL hold a need_fill latch: set when debounced tank_low = 1, cleared when debounced tank_high = 1, else hold; when both = 1, need_fill holds.
REQ-019 SHALL, on a cycle with moisture_valid = 1, set soil_dry if moisture < DRY_THRESHOLD, clear if moisture > WET_THRESHOLD, hold otherwise (equality at either threshold holds).
REQ-020 SHALL run a saturating stale counter: cleared by moisture_valid, else increments until STALE_CYCLES; on reaching STALE_CYCLES set stale and clear soil_dry.
REQ-021 SHALL, when moisture_valid coincides with stale expiry, give moisture_valid priority: counter cleared, stale cleared, REQ-019 applied.
REQ-022 SHALL register outputs from internal state each edge: sensor_fault = dbl_low & dbl_high; moisture_stale = stale; filling_condition = need_fill & !fault; watering_condition = soil_dry & !stale & !dbl_low & !need_fill & !fault.
REQ-023 SHALL guarantee watering_condition and filling_condition are never 1 in the same cycle.
REQ-024 SHALL, for a switch change held stable, update dependent outputs exactly DEBOUNCE_CYCLES+3 rising edges after the input changes.
REQ-025 SHALL update watering_condition 2 rising edges after the moisture_valid cycle that changes soil_dry.

Reset
REQ-026 SHALL, on the first rising edge with reset = 1, clear synchronizers, debounced values, debounce counters, need_fill, soil_dry, stale counter and stale; all four outputs 0 the following cycle.
REQ-027 SHALL, on reset asserted mid-operation, abandon any debounce in progress and any latched condition; no output retains its pre-reset value after the reset edge.
REQ-028 SHALL ignore moisture_valid and switch inputs on reset cycles.

Verification
REQ-029 SHALL cover: tank_low 0->1 held, DEBOUNCE_CYCLES=4 -> filling_condition rises exactly 7 edges later; a 3-cycle tank_low pulse -> no change.
REQ-030 SHALL cover: need_fill = 1, tank_high debounced 1 with tank_low 0 -> filling_condition falls; then moisture=60 valid -> watering_condition = 1 two edges later.
REQ-031 SHALL cover: soil_dry = 1, samples 100, 120 -> stays dry; sample 121 -> watering_condition drops two edges later.
REQ-032 SHALL cover: no moisture_valid for 1024 cycles -> moisture_stale = 1, watering_condition = 0; valid with 50 on expiry cycle -> stale stays 0.
REQ-033 SHALL cover: both switches debounced 1 -> sensor_fault = 1, both conditions 0, need_fill unchanged after fault clears.
REQ-034 SHALL cover: reset asserted during active debounce and watering -> all outputs 0 next cycle, full debounce restarts after release.
